// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the burst master's state enum.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001
  } hburst_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

endpackage

// File: rtl/ahb_master_xfer.sv
// AHB-Lite burst master: turns an arbiter start pulse into a pipelined
// NONSEQ/SEQ burst, streaming write beats from and read beats to the AXI side.
module ahb_master_xfer
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_writing,
  input  logic        start_reading,
  output logic        ack,
  input  logic [31:0] addr,
  input  logic [3:0]  len,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic        wready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        rlast,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_t      state;
  logic [3:0]  len_q;
  logic [3:0]  addr_cnt;
  logic [3:0]  beat_cnt;
  logic        dphase;
  logic        addr_acc;
  logic        dp_ok;
  logic        dp_err;

  assign addr_acc = HTRANS[1] & HREADY;
  assign dp_ok    = dphase & HREADY & (HRESP == RESP_OKAY);
  assign dp_err   = dphase & (HRESP == RESP_ERROR);
  assign ack      = (state == S_IDLE);

  // Write data and its handshake follow the live data phase, so they stay
  // combinational: the upstream buffer advances on the same edge HREADY closes a beat.
  assign wready   = dp_ok & HWRITE;
  assign HWDATA   = (dphase & HWRITE) ? wdata : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      len_q    <= 4'd0;
      addr_cnt <= 4'd0;
      beat_cnt <= 4'd0;
      dphase   <= 1'b0;
      HADDR    <= 32'h0;
      HWRITE   <= 1'b0;
      HTRANS   <= TRANS_IDLE;
      HSIZE    <= 3'd0;
      HBURST   <= BURST_SINGLE;
      rdata    <= 32'h0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      // Completed data phase: count it and hand read data upstream.
      if (dp_ok) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (!HWRITE) begin
          rvalid <= 1'b1;
          rdata  <= HRDATA;
          rlast  <= (beat_cnt == len_q);
        end
      end

      // First error cycle cancels any pending address phase before the case below.
      if (dp_err && state != S_ERR) begin
        HTRANS <= TRANS_IDLE;
        state  <= S_ERR;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_writing || start_reading) begin
              state    <= S_ADDR;
              HWRITE   <= start_writing;
              HADDR    <= addr;
              HTRANS   <= TRANS_NONSEQ;
              HSIZE    <= (size > 3'd2) ? 3'd2 : size;
              HBURST   <= (len == 4'd0) ? BURST_SINGLE : BURST_INCR;
              len_q    <= len;
              addr_cnt <= 4'd0;
              beat_cnt <= 4'd0;
            end
          end
          S_ADDR, S_BURST: begin
            if (addr_acc) begin
              dphase   <= 1'b1;
              addr_cnt <= addr_cnt + 4'd1;
              if (addr_cnt == len_q) begin
                HTRANS <= TRANS_IDLE;
                state  <= S_LAST;
              end else begin
                HTRANS <= TRANS_SEQ;
                HADDR  <= HADDR + (32'd1 << HSIZE);
                state  <= S_BURST;
              end
            end
          end
          S_LAST: begin
            if (dp_ok) begin
              dphase <= 1'b0;
              done   <= 1'b1;
              state  <= S_IDLE;
            end
          end
          S_ERR: begin
            if (HREADY) begin
              dphase <= 1'b0;
              done   <= 1'b1;
              err    <= 1'b1;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_xfer.sv
// Directed and randomized bursts against an AHB slave/upstream model kept in the bench.
module tb_ahb_master_xfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_writing, start_reading;
  logic        ack;
  logic [31:0] addr;
  logic [3:0]  len;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid, rlast, done, err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;

  int vectors = 0;
  int miscompares = 0;

  ahb_master_xfer dut (
    .clk(clk), .rst(rst),
    .start_writing(start_writing), .start_reading(start_reading), .ack(ack),
    .addr(addr), .len(len), .size(size),
    .wdata(wdata), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_ack",    32'(ack),    32'd1);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr",  HADDR,       32'd0);
    chk("rst_hwdata", HWDATA,      32'd0);
    chk("rst_rdata",  rdata,       32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize",  32'(HSIZE),  32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast",  32'(rlast),  32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
  endtask

  // One burst; the model predicts addresses, handshakes and responses beat by beat.
  task automatic run_burst(input bit wr, input bit both, input logic [31:0] a,
                           input logic [3:0] l, input logic [2:0] s,
                           input int wait_pct, input int first_wait,
                           input int err_beat, input bit inject, input int abort_at);
    logic [31:0] wbuf [16];
    logic [31:0] exp_rdata, rd, ea;
    int step, a_idx, dp_beat, w_idx, err_stage, wait_left, esize;
    bit w, dp_active, nxt_dp, exp_rv, exp_rlast, exp_done, exp_err, finished, hr, hresp_v;
    w     = wr | both;
    esize = (s > 3'd2) ? 2 : int'(s);
    step  = 1 << esize;
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
    a_idx = 0; dp_beat = 0; w_idx = 0; err_stage = 0; wait_left = 0;
    dp_active = 0; exp_rv = 0; exp_rlast = 0; exp_done = 0; exp_err = 0;
    finished = 0; exp_rdata = 0;

    @(posedge clk); #1;
    chk("ack_before_start", 32'(ack), 32'd1);
    start_writing = w;
    start_reading = !wr | both;
    addr = a; len = l; size = s; wdata = wbuf[0];
    HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); #1;
    start_writing = 0; start_reading = 0;
    addr = $urandom; len = 4'($urandom); size = 3'($urandom);

    for (int k = 1; k <= 200; k++) begin
      start_reading = 0;
      chk("ack",    32'(ack),    32'(exp_done));
      chk("done",   32'(done),   32'(exp_done));
      chk("err",    32'(err),    32'(exp_err));
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      chk("rlast",  32'(rlast),  32'(exp_rlast));
      if (exp_rv) chk("rdata", rdata, exp_rdata);
      if (exp_done) begin
        finished = 1;
        chk("htrans_at_done", 32'(HTRANS), 32'd0);
        if (wait_pct == 0 && first_wait == 0 && err_beat < 0)
          chk("latency_to_done", 32'(k), 32'(int'(l) + 3));
        break;
      end
      exp_rv = 0; exp_rlast = 0; exp_done = 0; exp_err = 0;
      if (w_idx < 16) wdata = wbuf[w_idx];

      // Slave response for this cycle
      hr = 1; hresp_v = 0;
      if (dp_active) begin
        if (err_stage == 1) begin hr = 1; hresp_v = 1; err_stage = 2; end
        else if (dp_beat == err_beat) begin hr = 0; hresp_v = 1; err_stage = 1; end
        else if (wait_left > 0) begin hr = 0; wait_left--; end
        else hr = ($urandom_range(0, 99) >= wait_pct);
      end
      HREADY = hr; HRESP = hresp_v;
      rd = $urandom; HRDATA = rd;
      if (inject && k == 2) start_reading = 1;

      if (k == abort_at) begin
        #1 rst = 0;
        #1 reset_checks();
        for (int c = 0; c < 2; c++) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done), 32'd0);
          chk("abort_ack",     32'(ack),  32'd1);
        end
        rst = 1; HREADY = 1; HRESP = 0;
        return;
      end

      #2;
      if (k == 1) chk("htrans_first", 32'(HTRANS), 32'd2);
      if (HTRANS != 2'd0) begin
        ea = a + 32'(a_idx * step);
        chk("addr_in_range", 32'(a_idx <= int'(l)), 32'd1);
        chk("haddr",  HADDR,         ea);
        chk("htrans", 32'(HTRANS),   (a_idx == 0) ? 32'd2 : 32'd3);
        chk("hwrite", 32'(HWRITE),   32'(w));
        chk("hsize",  32'(HSIZE),    32'(esize));
        chk("hburst", 32'(HBURST),   (l == 4'd0) ? 32'd0 : 32'd1);
      end
      if (err_stage == 2) chk("htrans_err_cancel", 32'(HTRANS), 32'd0);
      if (dp_active && w) chk("hwdata", HWDATA, wbuf[dp_beat]);
      chk("wready", 32'(wready), 32'(dp_active & w & hr & !hresp_v));

      nxt_dp = 0;
      if (dp_active) begin
        if (hresp_v && hr) begin exp_done = 1; exp_err = 1; end
        else if (hresp_v || !hr) nxt_dp = 1;
        else begin
          if (!w) begin exp_rv = 1; exp_rdata = rd; exp_rlast = (dp_beat == int'(l)); end
          else w_idx++;
          if (dp_beat == int'(l)) exp_done = 1;
        end
      end
      if (HTRANS[1] && hr) begin
        nxt_dp = 1; dp_beat = a_idx; a_idx++;
        if (dp_beat == 0) wait_left = first_wait;
      end
      dp_active = nxt_dp;
      @(posedge clk); #1;
    end
    chk("burst_finished", 32'(finished), 32'd1);
    if (inject) begin
      @(posedge clk); #1;
      chk("late_start_ignored_ack",    32'(ack),    32'd1);
      chk("late_start_ignored_htrans", 32'(HTRANS), 32'd0);
    end
  endtask

  initial begin
    rst = 0; start_writing = 0; start_reading = 0;
    addr = 0; len = 0; size = 0; wdata = 0;
    HRDATA = 0; HREADY = 1; HRESP = 0;
    repeat (2) @(posedge clk);
    #1 reset_checks();
    rst = 1;

    // wr, both, addr, len, size, wait%, first_wait, err_beat, inject, abort_at
    run_burst(1, 0, 32'h100, 4'd0, 3'd2, 0, 0, -1, 0, 0);  // single write
    run_burst(0, 0, 32'h200, 4'd3, 3'd2, 0, 0, -1, 0, 0);  // INCR4 read
    run_burst(1, 0, 32'h300, 4'd1, 3'd2, 0, 2, -1, 0, 0);  // wait states
    run_burst(0, 0, 32'h400, 4'd3, 3'd2, 0, 0,  1, 0, 0);  // error on beat 2
    run_burst(1, 1, 32'h500, 4'd1, 3'd1, 0, 0, -1, 1, 0);  // both starts, late start
    run_burst(0, 0, 32'h600, 4'd7, 3'd2, 0, 0, -1, 0, 4);  // reset mid INCR8
    run_burst(0, 0, 32'h700, 4'd2, 3'd0, 0, 0, -1, 0, 0);  // first start after reset
    run_burst(1, 0, 32'hFFFF_FFF8, 4'd3, 3'd7, 0, 0, -1, 0, 0); // wrap + size clamp

    for (int i = 0; i < 12; i++) begin
      automatic bit          rw = 1'($urandom_range(0, 1));
      automatic logic [3:0]  rl = 4'($urandom_range(0, 15));
      automatic int          eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(rl)) : -1;
      run_burst(rw, 0, $urandom, rl, 3'($urandom_range(0, 7)), 30, 0, eb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_master_xfer.md
AHB_MASTER_XFER -- requirements
Module: ahb_master_xfer

Interface
REQ-001 SHALL have these ports, clock and reset first: clk, rst, asynchronous, active-low; clock clk.
REQ-002 clk  in  1  rising-edge clock shared with the AXI side and HCLK.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 start_writing  in  1  one-cycle pulse from the arbiter; begin a write burst.
REQ-005 start_reading  in  1  one-cycle pulse from the arbiter; begin a read burst.
REQ-006 ack  out  1  high when idle and able to accept a start.
REQ-007 addr  in  32  burst start address, sampled on start.
REQ-008 len  in  4  beats minus one (0..15), sampled on start.
REQ-009 size  in  3  bytes per beat = 2^size, sampled on start.
REQ-010 wdata  in  32  current write beat; the upstream buffer holds it valid whenever wready can rise.
REQ-011 wready  out  1  current write beat consumed; present the next beat.
REQ-012 rdata  out  32  read beat data; rvalid  out  1  beat valid; rlast  out  1  final beat.
REQ-013 done  out  1  one-cycle pulse when the burst ends; err  out  1  valid with done, 1 = ERROR response.
REQ-014 HADDR  out  32; HWRITE  out  1; HTRANS  out  2; HSIZE  out  3; HBURST  out  3; HWDATA  out  32.
REQ-015 HRDATA  in  32; HREADY  in  1; HRESP  in  1 (AHB-Lite).

Function
REQ-016 SHALL use states IDLE, ADDR, BURST, LAST, ERR; ack = (state == IDLE).
REQ-017 In IDLE, a start pulse SHALL latch addr, len and size, set HWRITE from the start source and move to ADDR next cycle; ack SHALL be low from that cycle on.
REQ-018 If start_writing and start_reading are both high, the write SHALL win and the read SHALL be ignored.
REQ-019 Start pulses outside IDLE SHALL be ignored.
REQ-020 In ADDR, HTRANS SHALL be NONSEQ with HADDR = latched addr.
REQ-021 HBURST SHALL be SINGLE when len = 0, otherwise INCR.
REQ-022 HSIZE SHALL equal the latched size, with size > 2 clamped to 2.
REQ-023 Each address phase SHALL hold until HREADY = 1.
REQ-024 The next address SHALL be HADDR + 2^HSIZE, mod 2^32 wrap; 1 KB boundary crossing is the caller's responsibility and is not checked.
REQ-025 Subsequent address phases (BURST) SHALL drive SEQ.
REQ-026 After the last address phase is accepted, HTRANS SHALL be IDLE and the state SHALL be LAST.
REQ-027 Address and data phases SHALL pipeline: beat n+1's address overlaps beat n's data phase.
REQ-028 A 4-bit beat counter SHALL count completed data phases.
REQ-029 Write: HWDATA SHALL equal wdata during each data phase.
REQ-030 Write: wready SHALL pulse in each cycle a data phase completes (HREADY = 1, HRESP = 0).
REQ-031 Read: on each completed data phase, rdata SHALL be registered from HRDATA and rvalid SHALL rise in the next cycle; rlast SHALL accompany the (len+1)th beat.
REQ-032 done SHALL pulse in the cycle after the last data phase completes; err = 0 and state = IDLE in that same cycle (ack high).
REQ-033 HRESP = 1 with HREADY = 0 (first error cycle) SHALL drive HTRANS IDLE on the next cycle, cancelling the pending address phase.
REQ-034 The burst SHALL then stop in ERR.
REQ-035 After HREADY = 1 (second error cycle), done = 1 and err = 1 SHALL pulse next cycle.
REQ-036 On an error, no further rvalid or wready SHALL be issued and rlast SHALL NOT assert.
REQ-037 Zero-wait latency: a single write SHALL have NONSEQ at T+1 and done at T+3; a single read SHALL have rvalid and done at T+3 (T = start cycle).

Reset
REQ-038 rst low SHALL immediately give: state IDLE, ack = 1, HTRANS = IDLE, HADDR/HWDATA/rdata = 0, HWRITE = 0, HSIZE = 0, HBURST = SINGLE, wready = rvalid = rlast = done = err = 0, beat counter = 0.
REQ-039 Reset mid-burst SHALL abandon the burst with no done pulse; the first start after rst rises SHALL be accepted normally.

Structure
REQ-040 Shared package ahb_pkg SHALL hold the HTRANS (IDLE, BUSY, NONSEQ, SEQ), HBURST (SINGLE, INCR) and HRESP (OKAY, ERROR) encodings and the state enum.
REQ-041 The block SHALL be a single module with no sub-module; the address incrementer and beat counter are inline.

Verification
REQ-042 Single write: start_writing, addr=0x100, len=0, size=2, wdata=0xDEADBEEF, HREADY=1 -> NONSEQ/0x100 at T+1, HWDATA=0xDEADBEEF at T+2, wready T+2, done T+3, err=0.
REQ-043 INCR4 read: addr=0x200, len=3, size=2 -> HADDR 0x200, 0x204, 0x208, 0x20C (NONSEQ, SEQ, SEQ, SEQ); four rvalid beats, rlast on the fourth, done with it.
REQ-044 Wait states: INCR2 write, HREADY low 2 cycles in the first data phase -> HADDR/HTRANS/HWDATA held stable; wready only when HREADY high.
REQ-045 Error: INCR4 read, ERROR on beat 2 -> HTRANS IDLE in the second error cycle; only 1 rvalid; done = err = 1; no rlast.
REQ-046 Simultaneous starts: start_writing = start_reading = 1 -> HWRITE = 1; later start while ack = 0 ignored.
REQ-047 Reset mid-burst: rst low during beat 3 of INCR8 -> all outputs at reset values immediately; no done; the next start runs correctly.
